mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port 0 = CPU
//  load/store path (driven by the control unit's mem_rd/mem_wr), port 1 =
//  program loader / debug port. Serialises accesses, inserts a fixed memory
//  wait-state count, and returns read data plus a one-cycle done pulse per requester.
// PARAMETERS
//  AW   8   address width
//  DW   16  data width
//  LAT  2   memory access cycles (>=1); mem_en held for exactly LAT cycles
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  req        in   2   access request per port; held high until ack
//  we         in   2   per-port write enable (1=write, 0=read), valid with req
//  addr0/1    in   AW  per-port address, valid with req
//  wdata0/1   in   DW  per-port write data, valid with req
//  ack        out  2   one-cycle done pulse to the served port
//  rdata      out  DW  read data, valid in the ack cycle, held until next read
//  mem_en     out  1   memory enable
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, sampled on last access cycle
//  busy       out  1   1 in ACCESS or DONE
//  owner      out  1   port currently or last served
// BEHAVIOUR
//  Reset: state=IDLE; ack=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0,
//   mem_wdata=0, busy=0, owner=0, cnt=0, last=1 (port 0 wins first tie).
//  FSM (registered outputs):
//   IDLE:   any req -> pick winner, latch we/addr/wdata into mem_* regs,
//           mem_en=1, cnt=LAT-1, owner=winner -> ACCESS. No req -> stay IDLE.
//   ACCESS: cnt!=0 -> cnt--. cnt==0 -> mem_en=0, mem_we=0; on read,
//           rdata<=mem_rdata -> DONE.
//   DONE:   ack[owner]=1 for this cycle only; last<=owner -> IDLE.
//  Latency: req sampled at edge N -> ack high in cycle N+LAT+1 (LAT+2 cycles total).
//  Requester drops req in the cycle after ack; if still high in IDLE it is
//   treated as a new access.
//  req changes during ACCESS/DONE are ignored; latched fields are used.
//  Requests that lose arbitration wait in IDLE; nothing is dropped.
//  Writes leave rdata unchanged.
//  Arbitration applies only in IDLE; one transaction outstanding maximum.
//  LAT=1: ACCESS lasts one cycle; mem_en is high for one cycle.
//  Reset mid-transaction: immediate return to IDLE with reset values;
//   the access is aborted and no ack is issued.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: when both req are high in IDLE, grant the
//   port != last (alternate). A single requester is always granted.
//  Undefined: fixed priority, port 0 (CPU) always wins ties; last is
//   tracked but unused.
// TESTING (LAT=2 unless stated)
//  1 Port0 read addr 0x10, mem_rdata=0xBEEF -> mem_en 2 cycles, ack=01
//    at 4th cycle, rdata=0xBEEF, busy low next cycle.
//  2 Port1 write addr 0x20 data 0x1234 -> mem_we=1, mem_addr=0x20,
//    mem_wdata=0x1234 for 2 cycles, ack=10 once, rdata unchanged.
//  3 Both req held continuously, 4 txns -> RR_EN: owner 0,1,0,1;
//    without: 0,0,0,0 (port1 starves).
//  4 Reset asserted in ACCESS cycle 1 -> all outputs 0 at once, no ack;
//    after release a pending req0 restarts from IDLE.
//  5 LAT=1, port0 read -> mem_en 1 cycle, ack 3 cycles after req.
//  6 req0 toggles addr mid-ACCESS 0x10->0x11 -> mem_addr stays 0x10.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port data memory with fixed wait states.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; default is port 0 priority.
module mem_port_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last, last_d;
  logic          win;

  logic [1:0]    ack_d;
  logic [DW-1:0] rdata_d;
  logic          mem_en_d;
  logic          mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          owner_d;

  // On a tie, round-robin hands the grant to the port not served last.
  assign win = req[1] & (~req[0] | (RR & ~last));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      ack       <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      last      <= last_d;
      ack       <= ack_d;
      rdata     <= rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      owner     <= owner_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (|req) state_d = ACCESS;
      ACCESS:  if (cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt;
    last_d      = last;
    ack_d       = '0;
    rdata_d     = rdata;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    owner_d     = owner;
    unique case (state)
      IDLE: begin
        if (|req) begin
          mem_en_d    = 1'b1;
          mem_we_d    = win ? we[1] : we[0];
          mem_addr_d  = win ? addr1 : addr0;
          mem_wdata_d = win ? wdata1 : wdata0;
          cnt_d       = CW'(LAT - 1);
          owner_d     = win;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (!mem_we) rdata_d = mem_rdata;
          // Registered ack lands in the DONE cycle.
          ack_d = owner ? 2'b10 : 2'b01;
        end
      end
      DONE:    last_d = owner;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=2 main instance plus a LAT=1 instance.
// Ties follow ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, req_l1, we;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1, mem_rdata;

  logic [1:0]  ack, l1_ack;
  logic [15:0] rdata, l1_rdata;
  logic        mem_en, l1_mem_en;
  logic        mem_we, l1_mem_we;
  logic [7:0]  mem_addr, l1_mem_addr;
  logic [15:0] mem_wdata, l1_mem_wdata;
  logic        busy, l1_busy;
  logic        owner, l1_owner;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(16), .LAT(2)) u (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(8), .DW(16), .LAT(1)) u1 (
    .clk(clk), .reset(reset), .req(req_l1), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(l1_ack), .rdata(l1_rdata), .mem_en(l1_mem_en), .mem_we(l1_mem_we),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata),
    .busy(l1_busy), .owner(l1_owner)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic exp_own [4];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    reset = 1'b1;
    req = '0; req_l1 = '0; we = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_rdata = '0;
    tick(); tick();
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_busy_owner", {busy, owner}, 0);
    reset = 1'b0;
    tick();

    // port 0 read
    req = 2'b01; we = 2'b00; addr0 = 8'h10; mem_rdata = 16'hBEEF;
    tick();
    chk("t1_en_c1", mem_en, 1);
    chk("t1_busy", busy, 1);
    chk("t1_owner", owner, 0);
    chk("t1_ack_c1", ack, 0);
    tick();
    chk("t1_en_c2", mem_en, 1);
    chk("t1_addr", mem_addr, 8'h10);
    chk("t1_ack_c2", ack, 0);
    tick();
    chk("t1_ack", ack, 2'b01);
    chk("t1_rdata", rdata, 16'hBEEF);
    chk("t1_en_off", mem_en, 0);
    req = 2'b00;
    tick();
    chk("t1_busy_off", busy, 0);
    chk("t1_ack_off", ack, 0);

    // port 1 write
    req = 2'b10; we = 2'b10; addr1 = 8'h20; wdata1 = 16'h1234;
    mem_rdata = 16'hDEAD;
    tick();
    chk("t2_mem_c1", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h20, 16'h1234});
    chk("t2_owner", owner, 1);
    tick();
    chk("t2_mem_c2", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h20, 16'h1234});
    tick();
    chk("t2_ack", ack, 2'b10);
    chk("t2_rdata", rdata, 16'hBEEF);
    chk("t2_we_off", {mem_en, mem_we}, 0);
    req = 2'b00; we = 2'b00;
    tick();
    chk("t2_ack_once", ack, 0);

    // both held continuously
    req = 2'b11; addr0 = 8'h30; addr1 = 8'h40;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t3_owner%0d", k), owner, exp_own[k]);
      chk($sformatf("t3_addr%0d", k), mem_addr, exp_own[k] ? 8'h40 : 8'h30);
      tick(); tick();
      chk($sformatf("t3_ack%0d", k), ack, exp_own[k] ? 2'b10 : 2'b01);
      if (k == 3) req = 2'b00;
      tick();
    end
    chk("t3_idle", busy, 0);

    // reset during first access cycle
    req = 2'b01; addr0 = 8'h50; mem_rdata = 16'h5555;
    tick();
    chk("t4_en", mem_en, 1);
    reset = 1'b1;
    #1;
    chk("t4_rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    chk("t4_rst_state", {busy, owner, ack}, 0);
    chk("t4_rst_rdata", rdata, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t4_restart", {mem_en, busy, mem_addr}, {2'b11, 8'h50});
    tick();
    chk("t4_no_ack", ack, 0);
    tick();
    chk("t4_ack", ack, 2'b01);
    chk("t4_rdata", rdata, 16'h5555);
    req = 2'b00;
    tick();

    // LAT=1 instance
    req_l1 = 2'b01; addr0 = 8'h60; mem_rdata = 16'h7777;
    tick();
    chk("t5_en", {l1_mem_en, l1_ack}, {1'b1, 2'b00});
    chk("t5_addr", l1_mem_addr, 8'h60);
    tick();
    chk("t5_ack", l1_ack, 2'b01);
    chk("t5_en_off", l1_mem_en, 0);
    chk("t5_rdata", l1_rdata, 16'h7777);
    req_l1 = 2'b00;
    tick();
    chk("t5_idle", {l1_busy, l1_ack}, 0);

    // address change mid-access is ignored
    req = 2'b01; addr0 = 8'h10;
    tick();
    addr0 = 8'h11;
    chk("t6_addr_c1", mem_addr, 8'h10);
    tick();
    chk("t6_addr_c2", mem_addr, 8'h10);
    tick();
    chk("t6_ack", ack, 2'b01);
    req = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
